// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: segment patterns, count direction and
// the nibble-to-segment encoder used by the display scanner.
package stopwatch_pkg;

   typedef enum logic {
      MODE_UP   = 1'b0,
      MODE_DOWN = 1'b1
   } mode_e;

   // Common-anode, active-low patterns; bit7 is the decimal point (1 = dark).
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
      logic [7:0] s;
      case (nibble)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      s[7] = ~dp;
      return s;
   endfunction

endpackage

// File: rtl/stopwatch_scan_ctrl_bcd_digit.sv
// One modulo-M BCD digit that counts up or down, with a combinational
// carry/borrow output so a chain of digits updates in a single cycle.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int M = 10
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  mode_e      dir,
   input  logic       cin,
   input  logic       load,
   input  logic [3:0] ld_val,
   output logic [3:0] q,
   output logic       cout
);

   localparam logic [3:0] MAX = 4'(M - 1);

   logic [3:0] clamped;
   logic [3:0] nxt;

   assign clamped = (ld_val > MAX) ? MAX : ld_val;

   always_comb begin
      nxt = q;
      if (dir == MODE_DOWN) begin
         nxt = (q == 4'd0) ? MAX : q - 4'd1;
      end else begin
         nxt = (q == MAX) ? 4'd0 : q + 4'd1;
      end
   end

   // Carry out means this digit rolls over when the incoming carry arrives.
   assign cout = cin && ((dir == MODE_DOWN) ? (q == 4'd0) : (q == MAX));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q <= 4'd0;
      end else if (load) begin
         q <= clamped;
      end else if (en && cin) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/stopwatch_scan_ctrl.sv
// Stopwatch / countdown timer with lap freeze, wrap alarm and a multiplexed
// common-anode 7-segment scanner, all in the single clk domain.
module stopwatch_scan_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int TICK_DIV   = 1_000_000,
   parameter int SCAN_DIV   = 5_000,
   parameter int TOP_MOD    = 6,
   parameter int DP_POS     = 2,
   parameter int WARN_WRAPS = 2
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  run,
   input  logic                  mode,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  lap,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7:0]            seg_n,
   output logic [DIGITS-1:0]     an,
   output logic                  wrap_led,
   output logic                  warning,
   output logic                  expired
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int WW = (WARN_WRAPS > 0) ? $clog2(WARN_WRAPS + 1) : 1;

   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [WW-1:0] WARN_LVL  = WW'(WARN_WRAPS);

   mode_e               dir;
   logic [PW-1:0]       presc;
   logic                tick;
   logic                all_zero;
   logic                near_zero;
   logic                step_en;
   logic                expire_set;
   logic                full_wrap;
   logic [DIGITS:0]     carry;
   logic [WW-1:0]       wrap_cnt;
   logic [WW-1:0]       wrap_cnt_nxt;
   logic                frozen;
   logic [4*DIGITS-1:0] snap;
   logic [4*DIGITS-1:0] disp;
   logic [3:0]          disp_nib;
   logic [SW-1:0]       scan_cnt;
   logic [IW-1:0]       idx;

   assign dir       = mode_e'(mode);
   assign tick      = run && (presc == TICK_LAST);
   assign all_zero  = (bcd == '0);
   assign near_zero = (bcd[4*DIGITS-1:4] == '0) && (bcd[3:0] <= 4'd1);

   // Counting stops once expired, and a zero count never borrows into a wrap.
   assign step_en    = tick && !load && !expired && !((dir == MODE_DOWN) && all_zero);
   assign expire_set = tick && !load && !expired && (dir == MODE_DOWN) && near_zero;
   assign full_wrap  = step_en && (dir == MODE_UP) && carry[DIGITS];

   assign wrap_cnt_nxt = (wrap_cnt == WARN_LVL) ? wrap_cnt : wrap_cnt + WW'(1);

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit #(
         .M ((i == DIGITS - 1) ? TOP_MOD : 10)
      ) u_digit (
         .clk    (clk),
         .clr    (clr),
         .en     (step_en),
         .dir    (dir),
         .cin    (carry[i]),
         .load   (load),
         .ld_val (load_val[4*i +: 4]),
         .q      (bcd[4*i +: 4]),
         .cout   (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         presc <= '0;
      end else if (load || tick) begin
         presc <= '0;
      end else if (run) begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         expired  <= 1'b0;
         wrap_led <= 1'b0;
         wrap_cnt <= '0;
         warning  <= 1'b0;
      end else begin
         if (load) begin
            expired <= (dir == MODE_DOWN) && (load_val == '0);
         end else if (expire_set) begin
            expired <= 1'b1;
         end
         if (full_wrap) begin
            wrap_led <= ~wrap_led;
            wrap_cnt <= wrap_cnt_nxt;
            if (wrap_cnt_nxt == WARN_LVL) begin
               warning <= 1'b1;
            end
         end
      end
   end

   // Lap looks at the pre-load count, so a simultaneous load does not leak in.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         frozen <= 1'b0;
         snap   <= '0;
      end else if (lap) begin
         if (!frozen) begin
            snap   <= bcd;
            frozen <= 1'b1;
         end else begin
            frozen <= 1'b0;
         end
      end
   end

   assign disp = frozen ? snap : bcd;

   always_comb begin
      disp_nib = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            disp_nib = disp[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         an    <= DIGITS'(1);
         seg_n <= SEG_0;
      end else begin
         an    <= DIGITS'(1) << idx;
         seg_n <= seg_encode(disp_nib, idx == IW'(DP_POS));
      end
   end

endmodule

// File: tb/tb_stopwatch_scan_ctrl.sv
// Bench for stopwatch_scan_ctrl: table vectors, hand-written lap/scan/reset
// sequences and a randomized run, all shadowed by an arithmetic count model.
module tb_stopwatch_scan_ctrl;

   localparam int DIGITS     = 4;
   localparam int TICK_DIV   = 4;
   localparam int SCAN_DIV   = 2;
   localparam int TOP_MOD    = 6;
   localparam int DP_POS     = 2;
   localparam int WARN_WRAPS = 2;
   localparam int MAX_COUNT  = TOP_MOD * 1000 - 1;

   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic        clk;
   logic        clr;
   logic        run;
   logic        mode;
   logic        load;
   logic [15:0] load_val;
   logic        lap;
   logic [15:0] bcd;
   logic [7:0]  seg_n;
   logic [3:0]  an;
   logic        wrap_led;
   logic        warning;
   logic        expired;

   int errors = 0;
   int checks = 0;

   int   m_cnt, m_snap, m_presc, m_scan, m_idx, m_wraps;
   bit   m_frozen, m_expired, m_wrap_led, m_warning;
   logic [3:0] m_an;
   logic [7:0] m_seg;

   logic [7:0] disp_seg [4];

   typedef struct {
      logic        run;
      logic        mode;
      logic        load;
      logic [15:0] load_val;
      logic        lap;
      int          cycles;
      logic [15:0] exp_bcd;
      logic        exp_wrap;
      logic        exp_warn;
      logic        exp_expired;
   } vec_t;

   vec_t vecs [19];

   stopwatch_scan_ctrl #(
      .DIGITS     (DIGITS),
      .TICK_DIV   (TICK_DIV),
      .SCAN_DIV   (SCAN_DIV),
      .TOP_MOD    (TOP_MOD),
      .DP_POS     (DP_POS),
      .WARN_WRAPS (WARN_WRAPS)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .run      (run),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .lap      (lap),
      .bcd      (bcd),
      .seg_n    (seg_n),
      .an       (an),
      .wrap_led (wrap_led),
      .warning  (warning),
      .expired  (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int digit_of(input int v, input int d);
      int t;
      t = v;
      for (int i = 0; i < d; i++) t = t / 10;
      return t % 10;
   endfunction

   function automatic int clamp_value(input logic [15:0] lv);
      int v, p, nib, lim;
      v = 0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         nib = int'(lv[4*i +: 4]);
         lim = (i == 3) ? TOP_MOD : 10;
         if (nib >= lim) nib = lim - 1;
         v = v + nib * p;
         p = p * 10;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_cnt      = 0;
      m_snap     = 0;
      m_presc    = 0;
      m_scan     = 0;
      m_idx      = 0;
      m_wraps    = 0;
      m_frozen   = 0;
      m_expired  = 0;
      m_wrap_led = 0;
      m_warning  = 0;
      m_an       = 4'b0001;
      m_seg      = 8'hC0;
   endtask

   // Count is kept as a plain integer 0..MAX_COUNT; one call per clock edge.
   task automatic model_step();
      int  shown;
      bit  tick;
      tick  = run && (m_presc == TICK_DIV - 1);
      shown = m_frozen ? m_snap : m_cnt;
      m_an  = 4'(1 << m_idx);
      m_seg = SEG_TAB[digit_of(shown, m_idx)];
      if (m_idx == DP_POS) m_seg[7] = 1'b0;
      if (m_scan == SCAN_DIV - 1) begin
         m_scan = 0;
         m_idx  = (m_idx + 1) % DIGITS;
      end else begin
         m_scan++;
      end
      if (lap) begin
         if (!m_frozen) begin
            m_snap   = m_cnt;
            m_frozen = 1;
         end else begin
            m_frozen = 0;
         end
      end
      if (load) begin
         m_cnt     = clamp_value(load_val);
         m_presc   = 0;
         m_expired = mode && (load_val == 16'h0000);
      end else begin
         if (tick) m_presc = 0;
         else if (run) m_presc++;
         if (tick && !m_expired) begin
            if (!mode) begin
               if (m_cnt == MAX_COUNT) begin
                  m_cnt      = 0;
                  m_wrap_led = !m_wrap_led;
                  if (m_wraps < WARN_WRAPS) m_wraps++;
                  if (m_wraps == WARN_WRAPS) m_warning = 1;
               end else begin
                  m_cnt++;
               end
            end else if (m_cnt <= 1) begin
               m_cnt     = 0;
               m_expired = 1;
            end else begin
               m_cnt--;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
      end
   endtask

   task automatic check_model(input string tag);
      checkOutput({tag, "_model"},
                  {1'b0, bcd, an, seg_n, wrap_led, warning, expired},
                  {1'b0, to_bcd(m_cnt), m_an, m_seg, m_wrap_led, m_warning, m_expired});
   endtask

   // Called at a negedge: drive, let one posedge happen, compare at the next negedge.
   task automatic applyStimulus(input logic r, input logic md, input logic ld,
                                input logic [15:0] lv, input logic lp, input string tag);
      run      = r;
      mode     = md;
      load     = ld;
      load_val = lv;
      lap      = lp;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic collect_display(input string tag);
      for (int d = 0; d < 4; d++) disp_seg[d] = 8'h00;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, tag);
         for (int d = 0; d < 4; d++) begin
            if (an[d]) disp_seg[d] = seg_n;
         end
      end
   endtask

   initial begin
      logic [3:0]  exp_an  [19];
      logic [7:0]  exp_seg [19];
      logic        r_run, r_mode, r_load, r_lap;
      logic [15:0] r_val;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 40, 16'h0010, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h5998, 1'b0,  9, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h5999, 1'b0,  5, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b0,  5, 16'h0002, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  4, 16'h0001, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  4, 16'h0000, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 20, 16'h0000, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b0,  1, 16'h0005, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h9A9F, 1'b0,  1, 16'h5999, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,  3, 16'h5999, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0042, 1'b0,  1, 16'h0042, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,  2, 16'h0042, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 50, 16'h0042, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,  1, 16'h0042, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,  1, 16'h0043, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0,  1, 16'h0000, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 12, 16'h0000, 1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0,  1, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0,  4, 16'h0001, 1'b0, 1'b1, 1'b0};

      exp_an  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1,
                  4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2};
      exp_seg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'hB0, 8'h24, 8'h24, 8'hF9, 8'hF9, 8'h99, 8'h99, 8'hB0};

      run = 0; mode = 0; load = 0; load_val = '0; lap = 0;
      clr = 1'b1;
      #3 clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checkOutput("reset_bcd",     32'(bcd),      32'h0000);
      checkOutput("reset_an",      32'(an),       32'h1);
      checkOutput("reset_seg",     32'(seg_n),    32'hC0);
      checkOutput("reset_wrap",    32'(wrap_led), 32'h0);
      checkOutput("reset_warning", 32'(warning),  32'h0);
      checkOutput("reset_expired", 32'(expired),  32'h0);
      clr = 1'b1;

      $display("[TB] table-driven vectors");
      for (int k = 0; k < 19; k++) begin
         for (int c = 0; c < vecs[k].cycles; c++) begin
            applyStimulus(vecs[k].run, vecs[k].mode, vecs[k].load && (c == 0),
                          vecs[k].load_val, vecs[k].lap && (c == 0), $sformatf("vec%0d", k));
         end
         checkOutput($sformatf("vec%0d_bcd", k),     32'(bcd),      32'(vecs[k].exp_bcd));
         checkOutput($sformatf("vec%0d_wrap", k),    32'(wrap_led), 32'(vecs[k].exp_wrap));
         checkOutput($sformatf("vec%0d_warning", k), 32'(warning),  32'(vecs[k].exp_warn));
         checkOutput($sformatf("vec%0d_expired", k), 32'(expired),  32'(vecs[k].exp_expired));
      end

      $display("[TB] lap freeze");
      applyStimulus(1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, "lap_load");
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, "lap_on");
      for (int c = 0; c < 31; c++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "lap_run");
      checkOutput("lap_live_bcd", 32'(bcd), 32'h0020);
      collect_display("lap_frozen");
      checkOutput("lap_frozen_d0", 32'(disp_seg[0]), 32'hA4);
      checkOutput("lap_frozen_d1", 32'(disp_seg[1]), 32'hF9);
      checkOutput("lap_frozen_d2", 32'(disp_seg[2]), 32'h40);
      checkOutput("lap_frozen_d3", 32'(disp_seg[3]), 32'hC0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "lap_off");
      collect_display("lap_live");
      checkOutput("lap_live_d0", 32'(disp_seg[0]), 32'hC0);
      checkOutput("lap_live_d1", 32'(disp_seg[1]), 32'hA4);
      checkOutput("lap_live_d2", 32'(disp_seg[2]), 32'h40);
      checkOutput("lap_live_d3", 32'(disp_seg[3]), 32'hC0);

      $display("[TB] async reset mid-operation");
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0357, 1'b0, "rst_load");
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "rst_lap");
      checkOutput("rst_pre_warning", 32'(warning), 32'h1);
      @(posedge clk);
      model_step();
      #2 clr = 1'b0;
      #1;
      model_reset();
      check_model("rst_async");
      checkOutput("rst_async_bcd", 32'(bcd),   32'h0000);
      checkOutput("rst_async_an",  32'(an),    32'h1);
      checkOutput("rst_async_seg", 32'(seg_n), 32'hC0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;

      $display("[TB] restart and scan");
      for (int k = 0; k < 19; k++) begin
         if (k < 10) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "scan");
         else        applyStimulus(1'b0, 1'b0, (k == 10), 16'h1234, 1'b0, "scan");
         checkOutput($sformatf("scan_an_%0d", k + 1), 32'(an), 32'(exp_an[k]));
         if (k >= 11) checkOutput($sformatf("scan_seg_%0d", k + 1), 32'(seg_n), 32'(exp_seg[k]));
         if (k == 9)  checkOutput("restart_bcd", 32'(bcd), 32'h0002);
         if (k == 10) checkOutput("scan_load_bcd", 32'(bcd), 32'h1234);
      end

      $display("[TB] randomized run");
      r_mode = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r_run = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 63) == 0) r_mode = ~r_mode;
         r_load = ($urandom_range(0, 39) == 0);
         r_lap  = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0:       r_val = 16'($urandom);
            1:       r_val = 16'($urandom_range(0, 3));
            2:       r_val = 16'h5990 | 16'($urandom_range(0, 9));
            default: r_val = to_bcd(int'($urandom_range(0, MAX_COUNT)));
         endcase
         applyStimulus(r_run, r_mode, r_load, r_val, r_lap, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_scan_ctrl.md
Name: stopwatch_scan_ctrl

Overview:
Parametrised stopwatch/countdown timer with a time-multiplexed 7-segment driver and a wrap/alarm indicator.
- Counts BCD digits on a prescaled tick, up or down, with load, lap-freeze and expiry detection.
- Scans the digits onto a shared common-anode segment bus.
- Fully synchronous to one clock: no derived clocks, and no counter-output edges are used as clocks.
- Sits directly behind the board I/O pins in the demo top level.

Parameters:
- DIGITS, 4: number of BCD digits (2..8).
- TICK_DIV, 1_000_000: clk cycles per count tick (10 ms at 100 MHz).
- SCAN_DIV, 5_000: clk cycles per displayed digit.
- TOP_MOD, 6: modulus of the most-significant digit. All other digits are modulus 10.
- DP_POS, 2: digit index whose decimal point is lit.
- WARN_WRAPS, 2: number of full wraps before warning asserts.

Ports:
- clk, in, 1: system clock.
- clr, in, 1: asynchronous reset, active-low.
- run, in, 1: 1 = count, 0 = hold.
- mode, in, 1: 0 = count up, 1 = count down.
- load, in, 1: one-cycle pulse; loads load_val.
- load_val, in, 4*DIGITS: BCD preset, digit 0 in [3:0].
- lap, in, 1: one-cycle pulse; toggles display freeze.
- bcd, out, 4*DIGITS: live count.
- seg_n, out, 8: segments, active-low, bit7 = dp, bits6:0 = g..a.
- an, out, DIGITS: digit enable, one-hot, active-high.
- wrap_led, out, 1: toggles on every full wrap.
- warning, out, 1: sticky wrap alarm.
- expired, out, 1: countdown reached zero.

Behaviour:
- Reset (clr = 0, async):
  - digits, prescaler, scan counter and scan index = 0; frozen = 0.
  - an = 1, seg_n = 8'hC0.
  - wrap_led = warning = expired = 0.
  - Wrap counter = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while run = 1. With run = 0 it holds its value; it is not cleared.
  - tick is a one-cycle internal pulse when prescaler == TICK_DIV-1 and run = 1; the prescaler returns to 0 on that cycle.
- Up mode: on tick, digit 0 increments. Carry ripples combinationally so the whole count updates in the same cycle. Digit i wraps at its modulus.
- Full wrap (all digits at max, up mode) -> all digits 0.
  - wrap_led toggles.
  - Wrap counter increments, saturating at WARN_WRAPS.
  - warning = 1 once wrap counter == WARN_WRAPS; cleared only by clr.
- Down mode: on tick, decrement with borrow.
  - When the count reaches all-zero, expired is set to 1 on that cycle.
  - While expired = 1, ticks are ignored and the count holds at 0. There is no wrap in down mode.
  - expired clears on load or clr.
  - Changing mode while expired = 1 has no effect until load.
- Load priority: load > tick in the same cycle.
  - Digits take load_val next cycle; the prescaler clears to 0.
  - Any nibble >= its modulus is clamped to modulus-1.
  - Loading all-zero in down mode sets expired immediately.
- Lap:
  - A lap pulse with frozen = 0 captures the live count into the snapshot register and sets frozen.
  - A second lap clears frozen.
  - Counting continues while frozen; bcd always shows the live count.
  - Display source = snapshot if frozen, else live count.
  - lap and load in the same cycle: load applies, and lap is still processed against the pre-load count.
- Scan:
  - The scan counter runs regardless of run.
  - Every SCAN_DIV cycles, index advances 0..DIGITS-1 and wraps to 0.
  - an and seg_n are registered and valid 1 cycle after an index change. an = one-hot(index).
  - seg_n decode: standard 0..9 patterns (0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90).
  - Non-BCD nibble -> FF (blank).
  - bit7 is forced to 0 when index == DP_POS.
- No combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - MODE_UP / MODE_DOWN;
  - function seg_encode(nibble, dp).
- Sub-module bcd_digit: a single modulo-M up/down BCD digit with inputs en, dir, cin, load, ld_val and outputs q, cout. Instantiated DIGITS times; the top digit is instantiated with M = TOP_MOD.

Test Plan:
All scenarios use DIGITS = 4, TICK_DIV = 4, SCAN_DIV = 2, TOP_MOD = 6, WARN_WRAPS = 2.
1. Up count and carry: release clr, run = 1, mode = 0, 40 cycles -> bcd = 16'h0010 after 10 ticks. Load 16'h5998, 2 ticks -> 16'h0000, wrap_led = 1, warning = 0. One further full wrap -> wrap_led = 0, warning = 1.
2. Countdown and expiry: load 16'h0003, mode = 1, run = 1 -> 16'h0002, 0001, 0000 on successive ticks, expired = 1 on the tick reaching 0000. 20 more cycles -> still 0000. Load 16'h0005 -> expired = 0.
3. Hold and clamp:
   - run = 0 at prescaler = 2 for 50 cycles -> bcd and prescaler unchanged; resume -> next tick after 2 cycles.
   - load 16'h9A9F -> bcd = 16'h5999.
   - load and tick in the same cycle -> load_val wins.
4. Lap freeze: at count 0012 pulse lap -> displayed digits stay 0,0,1,2 while bcd advances to 0020. Second lap -> display follows live count.
5. Scan/decode: an sequence 0001, 0010, 0100, 1000, 0001 with a 2-cycle period. With count 16'h1234, seg_n = 99, B0, 24 (dp lit on digit 2), F9.
6. Async reset mid-operation: assert clr between clk edges with count 16'h0357, frozen = 1, warning = 1 -> all outputs at reset values immediately. After release, counting restarts from 0000.
